change_event_logger: RTL and testbench

- Synthesizable, parametrised successor to the team's simulation-only display/monitor tasks.
- Watches NUM_CH channels of WIDTH bits each and detects value changes in monitor mode, or samples every cycle in strobe mode.
- Timestamps each event and buffers it in a DEPTH-entry FIFO drained through a valid/ready port.
- Sits beside the logic under observation as an on-chip trace source.

---
 rtl/change_event_logger_if.sv | 35 +++
 rtl/change_event_logger.sv | 139 +++++++++++++
 tb/tb_change_event_logger.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/change_event_logger_if.sv
`default_nettype none
// ============================================================================
//  Module   : change_event_logger_if
//  Brief    : Valid/ready event stream carrying timestamp, change mask and
//             channel snapshot from the change event logger to its consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface change_event_logger_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int TS_W   = 16
);
    logic                    evt_valid;
    logic                    evt_ready;
    logic [TS_W-1:0]         evt_ts;
    logic [NUM_CH-1:0]       evt_mask;
    logic [NUM_CH*WIDTH-1:0] evt_data;

    modport master (
        output evt_valid,
        output evt_ts,
        output evt_mask,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ts,
        input  evt_mask,
        input  evt_data,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/change_event_logger.sv
`default_nettype none
// ============================================================================
//  Module   : change_event_logger
//  Brief    : On-chip trace source: timestamps channel changes (or every cycle
//             in strobe mode) into a FWFT FIFO drained over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module change_event_logger #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      mon_en,
    input  wire logic                      strobe_mode,
    input  wire logic [NUM_CH*WIDTH-1:0]   sig_in,
    input  wire logic                      clr_ovf,
    change_event_logger_if.master          evt,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           overflow,
    output logic [DROP_W-1:0]              drop_cnt
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_DW    = NUM_CH * WIDTH;
    localparam int              c_ENT_W = TS_W + NUM_CH + c_DW;
    localparam logic [c_AW:0]   c_FULL  = (c_AW+1)'(DEPTH);

    logic [TS_W-1:0]    r_ts;
    logic [c_DW-1:0]    r_prev;
    logic               r_en_d;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_cnt;
    logic [c_ENT_W-1:0] r_mem [DEPTH];

    logic [NUM_CH-1:0]  w_chg;
    logic               w_baseline;
    logic               w_push;
    logic [NUM_CH-1:0]  w_mask;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [c_ENT_W-1:0] w_head;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chg
            assign w_chg[k] = (sig_in[k*WIDTH +: WIDTH] != r_prev[k*WIDTH +: WIDTH]);
        end
    endgenerate

    // A rising enable always logs the full state, whatever the mode.
    assign w_baseline = mon_en & ~r_en_d;
    assign w_push     = w_baseline
                      | (mon_en & r_en_d & strobe_mode)
                      | (mon_en & r_en_d & ~strobe_mode & (|w_chg));
    assign w_mask     = w_baseline ? {NUM_CH{1'b1}} : w_chg;

    assign w_full  = (r_count == c_FULL);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & evt.evt_ready;
    // When full, a same-cycle pop frees the slot the write pointer targets.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts   <= '0;
            r_prev <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_ts   <= r_ts + TS_W'(1);
            r_prev <= sig_in;
            r_en_d <= mon_en;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_ts, w_mask, sig_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the clearing cycle wins, leaving a fresh count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? DROP_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (!(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign evt.evt_valid = w_valid;
    assign evt.evt_ts    = w_head[c_ENT_W-1 -: TS_W];
    assign evt.evt_mask  = w_head[c_DW +: NUM_CH];
    assign evt.evt_data  = w_head[c_DW-1:0];

    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_change_event_logger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_change_event_logger
//  Brief    : Directed self-checking bench for change_event_logger.
//  Revision : 1.0  initial release
// ============================================================================
module tb_change_event_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_en;
    logic        strobe_mode;
    logic [31:0] sig_in;
    logic        clr_ovf;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;
    int tb_ts  = 0;
    int t0;

    logic [15:0] exp_ts   [21];
    logic [3:0]  exp_mask [21];
    logic [31:0] exp_data [21];

    change_event_logger_if #(.NUM_CH(4), .WIDTH(8), .TS_W(16)) evt_if ();

    change_event_logger #(
        .NUM_CH(4), .WIDTH(8), .DEPTH(16), .TS_W(16), .DROP_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mon_en      (mon_en),
        .strobe_mode (strobe_mode),
        .sig_in      (sig_in),
        .clr_ovf     (clr_ovf),
        .evt         (evt_if),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; mon_en = 1'b0; strobe_mode = 1'b0; sig_in = '0;
        clr_ovf = 1'b0; evt_if.evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(evt_if.evt_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_ts",    64'(evt_if.evt_ts), 64'd0);
        chk("rst_mask",  64'(evt_if.evt_mask), 64'd0);
        chk("rst_data",  64'(evt_if.evt_data), 64'd0);
        rst_n = 1'b1;
        tb_ts = 0;

        // Baseline at ts=5
        while (tb_ts != 5) step();
        mon_en = 1'b1;
        step();
        chk("base_valid", 64'(evt_if.evt_valid), 64'd1);
        chk("base_ts",    64'(evt_if.evt_ts), 64'd5);
        chk("base_mask",  64'(evt_if.evt_mask), 64'hF);
        chk("base_data",  64'(evt_if.evt_data), 64'd0);
        chk("base_count", 64'(fifo_count), 64'd1);
        repeat (2) step();
        chk("silence_count", 64'(fifo_count), 64'd1);
        chk("hold_ts",       64'(evt_if.evt_ts), 64'd5);
        evt_if.evt_ready = 1'b1;
        step();
        chk("pop_valid", 64'(evt_if.evt_valid), 64'd0);

        // Monitor mode
        while (tb_ts != 10) step();
        sig_in[15:8] = 8'hAB;
        step();
        chk("mon1_valid", 64'(evt_if.evt_valid), 64'd1);
        chk("mon1_ts",    64'(evt_if.evt_ts), 64'd10);
        chk("mon1_mask",  64'(evt_if.evt_mask), 64'h2);
        chk("mon1_data",  64'(evt_if.evt_data), 64'h0000AB00);
        step();
        chk("mon1_popped", 64'(evt_if.evt_valid), 64'd0);
        sig_in[31:24] = 8'h01;
        step();
        chk("mon2_ts",   64'(evt_if.evt_ts), 64'd12);
        chk("mon2_mask", 64'(evt_if.evt_mask), 64'h8);
        chk("mon2_data", 64'(evt_if.evt_data), 64'h0100AB00);
        step();
        sig_in[7:0] = 8'h00;
        repeat (2) step();
        chk("mon_same_none", 64'(fifo_count), 64'd0);

        // Strobe mode
        mon_en = 1'b0; evt_if.evt_ready = 1'b0;
        step();
        strobe_mode = 1'b1; mon_en = 1'b1;
        t0 = tb_ts;
        repeat (5) step();
        mon_en = 1'b0;
        chk("strb_count", 64'(fifo_count), 64'd5);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("strb_ts",   64'(evt_if.evt_ts), 64'(t0 + i));
            chk("strb_mask", 64'(evt_if.evt_mask), (i == 0) ? 64'hF : 64'h0);
            chk("strb_data", 64'(evt_if.evt_data), 64'h0100AB00);
            step();
        end
        chk("strb_drained", 64'(fifo_count), 64'd0);

        // Overflow: 20 events into a 16-deep FIFO
        strobe_mode = 1'b0; evt_if.evt_ready = 1'b0;
        step();
        t0 = tb_ts;
        for (int i = 0; i < 20; i++) begin
            mon_en = 1'b1;
            sig_in[0] = ~sig_in[0];
            exp_ts[i]   = 16'(t0 + i);
            exp_mask[i] = (i == 0) ? 4'hF : 4'h1;
            exp_data[i] = sig_in;
            step();
        end
        chk("ovf_count", 64'(fifo_count), 64'd16);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_drop",  64'(drop_cnt), 64'd4);
        chk("ovf_head_ts",   64'(evt_if.evt_ts), 64'(exp_ts[0]));
        chk("ovf_head_mask", 64'(evt_if.evt_mask), 64'(exp_mask[0]));

        // Full with simultaneous push and pop
        evt_if.evt_ready = 1'b1;
        sig_in[0] = ~sig_in[0];
        exp_ts[20] = 16'(t0 + 20); exp_mask[20] = 4'h1; exp_data[20] = sig_in;
        step();
        evt_if.evt_ready = 1'b0; mon_en = 1'b0;
        chk("pp_count", 64'(fifo_count), 64'd16);
        chk("pp_drop",  64'(drop_cnt), 64'd4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf",  64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        evt_if.evt_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            int idx;
            idx = (j < 16) ? j : 20;
            chk("drain_ts",   64'(evt_if.evt_ts), 64'(exp_ts[idx]));
            chk("drain_mask", 64'(evt_if.evt_mask), 64'(exp_mask[idx]));
            chk("drain_data", 64'(evt_if.evt_data), 64'(exp_data[idx]));
            step();
        end
        chk("drain_empty", 64'(fifo_count), 64'd0);

        // Reset mid-stream with 7 events buffered
        evt_if.evt_ready = 1'b0; strobe_mode = 1'b1;
        step();
        mon_en = 1'b1;
        repeat (7) step();
        mon_en = 1'b0;
        chk("pre_rst_count", 64'(fifo_count), 64'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(evt_if.evt_valid), 64'd0);
        chk("arst_count", 64'(fifo_count), 64'd0);
        chk("arst_data",  64'(evt_if.evt_data), 64'd0);
        strobe_mode = 1'b0; mon_en = 1'b1;
        #1 rst_n = 1'b1;
        tb_ts = 0;
        step();
        chk("post_rst_valid", 64'(evt_if.evt_valid), 64'd1);
        chk("post_rst_ts",    64'(evt_if.evt_ts), 64'd0);
        chk("post_rst_mask",  64'(evt_if.evt_mask), 64'hF);
        chk("post_rst_data",  64'(evt_if.evt_data), 64'(sig_in));
        chk("post_rst_count", 64'(fifo_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
